uart_tx_buf: RTL and testbench

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_tx_buf.sv | 138 +++++++++++++
 tb/tb_uart_tx_buf.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - UART transmitter with a one-byte holding register ahead of the shifter
// The holding register lets a second byte queue up so frames can run back to back.
module uart_tx_buf #(
  parameter int CLK_PER_BIT = 50,
  parameter int PARITY      = 0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tx,
  input  logic       block,
  output logic       busy,
  input  logic [7:0] data,
  input  logic       new_data
);

  localparam int            CW       = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam bit            PAR_EN   = (PARITY == 1) || (PARITY == 2);
  localparam bit            PAR_ODD  = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          hold_full;
  logic [7:0]    hold_data;
  logic          bit_end;
  logic          launch;

  assign busy    = hold_full;
  assign bit_end = (cnt == CNT_LAST);
  // block only matters at the moment a new frame would begin
  assign launch  = hold_full && !block;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      hold_full <= 1'b0;
      hold_data <= '0;
      tx        <= 1'b1;
    end else begin
      if (new_data && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= data;
      end

      case (state)
        S_IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
          if (launch) begin
            state     <= S_START;
            tx        <= 1'b0;
            shreg     <= hold_data;
            par_bit   <= PAR_ODD ? ~^hold_data : ^hold_data;
            hold_full <= 1'b0;
          end
        end

        S_START: begin
          if (bit_end) begin
            cnt     <= '0;
            state   <= S_DATA;
            bit_idx <= '0;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              if (PAR_EN) begin
                state <= S_PARITY;
                tx    <= par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= S_STOP;
            tx    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            // chain straight into the next start bit when a byte is waiting
            if (launch) begin
              state     <= S_START;
              tx        <= 1'b0;
              shreg     <= hold_data;
              par_bit   <= PAR_ODD ? ~^hold_data : ^hold_data;
              hold_full <= 1'b0;
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - self-checking bench for uart_tx_buf (three parity variants side by side)
module tb_uart_tx_buf;

  localparam int CPB  = 4;
  localparam int LOGN = 8192;

  typedef struct {
    int         mode;
    logic [7:0] d;
    logic [19:0] pat;
    int         nbits;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       block;
  logic       new_data;
  logic [7:0] data;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  logic tx_log   [3][LOGN];
  logic busy_log [3][LOGN];

  // frame-as-queue reference: each accepted byte expands into per-cycle tx levels
  bit         m_full  [3];
  logic [7:0] m_byte  [3];
  bit         m_tx    [3];
  bit         m_frame [3][48];
  int         m_len   [3];
  int         m_pos   [3];

  always #5 clk = ~clk;

  uart_tx_buf #(.CLK_PER_BIT(CPB), .PARITY(0)) u0 (
    .clk(clk), .rst(rst), .tx(tx0), .block(block), .busy(busy0), .data(data), .new_data(new_data));
  uart_tx_buf #(.CLK_PER_BIT(CPB), .PARITY(1)) u1 (
    .clk(clk), .rst(rst), .tx(tx1), .block(block), .busy(busy1), .data(data), .new_data(new_data));
  uart_tx_buf #(.CLK_PER_BIT(CPB), .PARITY(2)) u2 (
    .clk(clk), .rst(rst), .tx(tx2), .block(block), .busy(busy2), .data(data), .new_data(new_data));

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step(input int k);
    bit was_full;
    bit b[11];
    int nb;
    was_full = m_full[k];
    if (rst) begin
      m_full[k] = 1'b0;
      m_tx[k]   = 1'b1;
      m_len[k]  = 0;
      m_pos[k]  = 0;
    end else begin
      if (m_pos[k] < m_len[k]) begin
        m_tx[k] = m_frame[k][m_pos[k]];
        m_pos[k]++;
      end else if (m_full[k] && !block) begin
        nb = (k == 0) ? 10 : 11;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = m_byte[k][i];
        if (k == 1) b[9] = ($countones(m_byte[k]) % 2 == 0);
        if (k == 2) b[9] = ($countones(m_byte[k]) % 2 == 1);
        b[nb-1] = 1'b1;
        for (int i = 0; i < nb; i++)
          for (int c = 0; c < CPB; c++)
            m_frame[k][i*CPB + c] = b[i];
        m_len[k]  = nb * CPB;
        m_tx[k]   = m_frame[k][0];
        m_pos[k]  = 1;
        m_full[k] = 1'b0;
      end else begin
        m_tx[k] = 1'b1;
      end
      if (new_data && !was_full) begin
        m_full[k] = 1'b1;
        m_byte[k] = data;
      end
    end
  endtask

  task automatic check_frame(input int k, input int s, input logic [19:0] pat,
                             input int nbits, input string nm);
    for (int i = 0; i < nbits; i++)
      for (int c = 0; c < CPB; c++)
        chk($sformatf("%s_bit%0d", nm, i), tx_log[k][s + i*CPB + c], pat[i]);
  endtask

  task automatic send(input logic [7:0] d, output int a);
    a        = cyc;
    data     = d;
    new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_full[k] = 1'b0;
      m_byte[k] = 8'h00;
      m_tx[k]   = 1'b1;
      m_len[k]  = 0;
      m_pos[k]  = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 3; k++) model_step(k);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cyc < LOGN) begin
        tx_log[0][cyc]   = tx0;
        tx_log[1][cyc]   = tx1;
        tx_log[2][cyc]   = tx2;
        busy_log[0][cyc] = busy0;
        busy_log[1][cyc] = busy1;
        busy_log[2][cyc] = busy2;
      end
      if (chk_en) begin
        chk("model_tx0", tx0, m_tx[0]);
        chk("model_tx1", tx1, m_tx[1]);
        chk("model_tx2", tx2, m_tx[2]);
        chk("model_busy0", busy0, m_full[0]);
        chk("model_busy1", busy1, m_full[1]);
        chk("model_busy2", busy2, m_full[2]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[5];
    int   a;
    int   s;
    int   r;
    int   len;
    int   m;

    tbl[0] = '{0, 8'h55, 20'h002AA, 10};
    tbl[1] = '{2, 8'h07, 20'h0060E, 11};
    tbl[2] = '{1, 8'h07, 20'h0040E, 11};
    tbl[3] = '{1, 8'h00, 20'h00600, 11};
    tbl[4] = '{0, 8'hA5, 20'h0034A, 10};

    rst = 1'b1; block = 1'b0; new_data = 1'b0; data = 8'h00;
    gap(3);
    chk_en = 1'b1;
    rst    = 1'b0;
    chk("reset_tx", tx0, 1'b1);
    chk("reset_busy", busy0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      data     = 8'($urandom);
      new_data = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) block = ~block;
      rst      = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b1; new_data = 1'b0; block = 1'b0;
    gap(1);
    rst = 1'b0;
    gap(5);

    for (int i = 0; i < 5; i++) begin
      m   = tbl[i].mode;
      len = tbl[i].nbits * CPB;
      send(tbl[i].d, a);
      gap(len + 6);
      check_frame(m, a + 2, tbl[i].pat, tbl[i].nbits, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_idle_before", i), tx_log[m][a+1], 1'b1);
      chk($sformatf("tbl%0d_busy_acc", i), busy_log[m][a+1], 1'b1);
      chk($sformatf("tbl%0d_busy_start", i), busy_log[m][a+2], 1'b0);
      chk($sformatf("tbl%0d_idle_after", i), tx_log[m][a+2+len], 1'b1);
      gap(4);
    end

    send(8'hA5, a);
    s = a + 2;
    gap(1);
    send(8'h3C, r);
    while (cyc < s + 39) @(negedge clk);
    send(8'h77, r);
    gap(50);
    check_frame(0, s, {10'h278, 10'h34A}, 20, "b2b");
    chk("b2b_busy_start", busy_log[0][s], 1'b0);
    chk("b2b_busy_hold", busy_log[0][s+1], 1'b1);
    chk("b2b_busy_stop", busy_log[0][s+39], 1'b1);
    chk("b2b_busy_xfer", busy_log[0][s+40], 1'b0);
    for (int j = s + 80; j < s + 88; j++) begin
      chk("b2b_drop_tx", tx_log[0][j], 1'b1);
      chk("b2b_drop_busy", busy_log[0][j], 1'b0);
    end

    block = 1'b1;
    send(8'h41, a);
    gap(5);
    send(8'h42, r);
    gap(3);
    r     = cyc;
    block = 1'b0;
    gap(60);
    for (int j = a + 1; j <= r; j++) begin
      chk("blk_busy", busy_log[0][j], 1'b1);
      chk("blk_tx", tx_log[0][j], 1'b1);
    end
    chk("blk_busy_release", busy_log[0][r+1], 1'b0);
    check_frame(0, r + 1, 20'h00282, 10, "blk");
    for (int j = r + 41; j < r + 55; j++) begin
      chk("blk_no_second_tx", tx_log[0][j], 1'b1);
      chk("blk_no_second_busy", busy_log[0][j], 1'b0);
    end

    send(8'hF0, a);
    s = a + 2;
    while (cyc < s + 4*CPB + 1) @(negedge clk);
    r        = cyc;
    rst      = 1'b1;
    data     = 8'h99;
    new_data = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    new_data = 1'b0;
    gap(5);
    chk("rst_pre_tx", tx_log[0][r], 1'b0);
    for (int j = r + 1; j < r + 5; j++) begin
      chk("rst_tx", tx_log[0][j], 1'b1);
      chk("rst_busy", busy_log[0][j], 1'b0);
    end
    send(8'h0F, a);
    gap(50);
    check_frame(0, a + 2, 20'h0021E, 10, "post_rst");
    chk("post_rst_idle", tx_log[0][a+42], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
